ami_port_arbiter: RTL and testbench
===================================

Name: ami_port_arbiter

Overview:
Shares a single AMI memory port between NUM_REQ requesters, for example a DNN2AMI read path, a DNN2AMI write path and a BlockBuffer. Requests are scheduled round-robin. Each accepted read gets a routing tag, and responses, which return in order, are sent back to the requester that issued the read. The block sits between the app-side requesters and one AmorphOSMem2SDRAM port.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ADDR_WIDTH, 64, byte address width.
DATA_WIDTH, 512, request/response data width.
SIZE_WIDTH, 64, request size field width.
LOG_TAG_DEPTH, 4, log2 of the routing FIFO depth, which is the maximum number of outstanding reads.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_is_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i
req_data  in  NUM_REQ*DATA_WIDTH  packed write data
req_size  in  NUM_REQ*SIZE_WIDTH  packed sizes
req_grant  out  NUM_REQ  one-hot; request captured this cycle
resp_valid  out  NUM_REQ  one-hot response valid
resp_data  out  DATA_WIDTH  response data, shared by all requesters
resp_grant  in  NUM_REQ  requester consumes its response
mem_req_valid  out  1  downstream request valid
mem_req_is_write  out  1  downstream write flag
mem_req_addr  out  ADDR_WIDTH  downstream address
mem_req_data  out  DATA_WIDTH  downstream data
mem_req_size  out  SIZE_WIDTH  downstream size
mem_req_grant  in  1  downstream accepted mem_req this cycle
mem_resp_valid  in  1  downstream response valid
mem_resp_data  in  DATA_WIDTH  downstream response data
mem_resp_grant  out  1  response consumed
outstanding_reads  out  LOG_TAG_DEPTH+1  current count of outstanding reads

Behaviour:
- Handshakes: a transfer occurs on any cycle with valid & grant. A requester holds valid and its payload stable until it sees grant.
- Output register: one entry holding mem_req_*.
  - Register empty: state IDLE.
  - Register full: state HOLD.
  - Leaving HOLD: on mem_req_grant.
- Selection:
  - The register can load when it is empty, or in the same cycle it is being drained (mem_req_valid & mem_req_grant). Back-to-back throughput is 1 request per cycle.
  - A requester is eligible when req_valid[i]=1, and for reads only when the routing FIFO will not be full after any same-cycle pop.
  - Round-robin starts at pointer rr_ptr. The first eligible index (rr_ptr+k) mod NUM_REQ for k=0..NUM_REQ-1 wins.
  - On a win: req_grant[winner]=1 combinationally in that cycle, the payload is registered, and rr_ptr <= (winner+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no winner.
- Routing FIFO:
  - Depth 2^LOG_TAG_DEPTH; entries are requester indices.
  - Push: on downstream acceptance of a read (mem_req_valid & mem_req_grant & ~mem_req_is_write).
  - Pop: on mem_resp_valid & mem_resp_grant.
  - Simultaneous push and pop: occupancy is unchanged.
  - Pointers wrap modulo depth; occupancy counter width is LOG_TAG_DEPTH+1.
  - outstanding_reads = occupancy.
- Response routing:
  - resp_valid[head]=mem_resp_valid when the FIFO is non-empty.
  - resp_data=mem_resp_data.
  - mem_resp_grant=resp_grant[head] & mem_resp_valid.
- Boundary conditions:
  - FIFO full: reads are blocked, writes still proceed.
  - mem_resp_valid while FIFO empty: protocol error. resp_valid stays 0, mem_resp_grant=0, and under simulation a $display error is printed.
  - Writes never push and produce no response.
- Reset:
  - Values: mem_req_valid=0, req_grant=0, resp_valid=0, mem_resp_grant=0, rr_ptr=0, FIFO empty, outstanding_reads=0. Register payload is don't-care.
  - Reset mid-operation discards any held request and all routing state. Responses in flight downstream after reset are treated as the protocol error above.

Optional Feature:
Macro: AMI_ARB_STATS_EN.
- When defined: adds output stat_grant_count, width NUM_REQ*32, holding per-requester saturating counters (stick at 32'hFFFFFFFF). A counter increments on each req_grant[i] and resets to 0 on rst.
- When undefined: the port and the counters are absent; behaviour is otherwise identical.

Test Plan:
1. Fairness: reset, then hold req_valid=4'b1111, all writes, mem_req_grant=1 constantly. Required: grants go 0,1,2,3,0,... one per cycle, with mem_req_addr matching each requester's slice.
2. Backpressure: requester 2 writes addr 0x40 while mem_req_grant=0 for 5 cycles. Required: req_grant[2] pulses once, mem_req fields stay stable for 5 cycles, and no other grant occurs.
3. Read routing: requester 1 reads 0x0, then requester 3 reads 0x40; responses D0 and D1 arrive in order. Required: resp_valid=4'b0010 with D0, then 4'b1000 with D1, and outstanding_reads goes 2 then 1 then 0.
4. FIFO full: LOG_TAG_DEPTH=2; issue 4 reads with no responses, then requester 0 reads while requester 1 writes. Required: only requester 1 is granted. After one response pops, requester 0 is granted.
5. Push/pop collision: with outstanding_reads=3, a read is accepted in the same cycle a response is consumed. Required: outstanding_reads stays 3 and the tag order is preserved.
6. Mid-operation reset: assert rst while in HOLD with 2 reads outstanding. Required: the next cycle shows mem_req_valid=0 and outstanding_reads=0, and with AMI_ARB_STATS_EN defined all counters read 0.

Source files
------------

// File: rtl/ami_port_arbiter.sv
// Round-robin arbiter sharing one AMI memory port among NUM_REQ requesters, with in-order read response routing.
// Optional macro AMI_ARB_STATS_EN adds per-requester saturating grant counters on stat_grant_count.
module ami_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 512,
  parameter int SIZE_WIDTH    = 64,
  parameter int LOG_TAG_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_is_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0] req_size,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  input  logic [NUM_REQ-1:0]            resp_grant,
  output logic                          mem_req_valid,
  output logic                          mem_req_is_write,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [DATA_WIDTH-1:0]         mem_req_data,
  output logic [SIZE_WIDTH-1:0]         mem_req_size,
  input  logic                          mem_req_grant,
  input  logic                          mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_resp_data,
  output logic                          mem_resp_grant,
  output logic [LOG_TAG_DEPTH:0]        outstanding_reads
`ifdef AMI_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         stat_grant_count
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DEPTH = 1 << LOG_TAG_DEPTH;
  localparam int CNT_W = LOG_TAG_DEPTH + 2;

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         src_q;
  logic                     is_write_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [SIZE_WIDTH-1:0]    size_q;
  logic [IDX_W-1:0]         tag_mem_q [DEPTH];
  logic [LOG_TAG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_TAG_DEPTH:0]   count_q, count_d;

  logic                     hold_s, drain_s, can_load_s, push_s, pop_s;
  logic                     fifo_empty_s, read_ok_s, win_found_s, grant_s;
  logic [IDX_W-1:0]         win_idx_s, cand_s, head_s;
  logic [IDX_W:0]           sum_s;
  logic [CNT_W-1:0]         count_proj_s;

  assign hold_s       = (state_q == HOLD);
  assign drain_s      = hold_s & mem_req_grant;
  assign can_load_s   = ~hold_s | drain_s;
  assign push_s       = drain_s & ~is_write_q;
  assign pop_s        = mem_resp_grant;
  assign fifo_empty_s = (count_q == '0);
  assign head_s       = tag_mem_q[rd_ptr_q];

  // Occupancy after this cycle's push/pop; a read may only load if that leaves a free slot.
  assign count_proj_s = CNT_W'(count_q) + CNT_W'(push_s) - CNT_W'(pop_s);
  assign count_d      = count_proj_s[LOG_TAG_DEPTH:0];
  assign read_ok_s    = (count_proj_s < CNT_W'(DEPTH));
  assign grant_s      = can_load_s & win_found_s & ~rst;

  // State register: output-slot FSM and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic: a drain with a same-cycle load keeps the slot full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant_s ? HOLD : IDLE;
      HOLD:    state_d = (grant_s || !mem_req_grant) ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the downstream request is the held slot.
  always_comb begin
    mem_req_valid    = hold_s;
    mem_req_is_write = is_write_q;
    mem_req_addr     = addr_q;
    mem_req_data     = data_q;
    mem_req_size     = size_q;
  end

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    sum_s       = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum_s >= (IDX_W+1)'(NUM_REQ)) sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
      else                              sum_s = sum_s;
      cand_s = sum_s[IDX_W-1:0];
      if (!win_found_s && req_valid[cand_s] && (req_is_write[cand_s] || read_ok_s)) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant vector and pointer advance.
  always_comb begin
    req_grant = '0;
    rr_ptr_d  = rr_ptr_q;
    if (grant_s) begin
      req_grant = NUM_REQ'(1) << win_idx_s;
      rr_ptr_d  = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_s + IDX_W'(1);
    end else begin
      req_grant = '0;
    end
  end

  // Payload slot; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (grant_s) begin
      src_q      <= win_idx_s;
      is_write_q <= req_is_write[win_idx_s];
      addr_q     <= req_addr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      data_q     <= req_data[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
      size_q     <= req_size[win_idx_s*SIZE_WIDTH +: SIZE_WIDTH];
    end
  end

  // Routing FIFO of requester tags for accepted reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        tag_mem_q[wr_ptr_q] <= src_q;
        wr_ptr_q            <= wr_ptr_q + LOG_TAG_DEPTH'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + LOG_TAG_DEPTH'(1);
      count_q <= count_d;
    end
  end

  assign outstanding_reads = count_q;
  assign resp_data         = mem_resp_data;

  // Steer the in-order response to the requester at the FIFO head.
  always_comb begin
    resp_valid     = '0;
    mem_resp_grant = 1'b0;
    if (!rst && !fifo_empty_s && mem_resp_valid) begin
      resp_valid     = NUM_REQ'(1) << head_s;
      mem_resp_grant = resp_grant[head_s];
    end else begin
      resp_valid     = '0;
      mem_resp_grant = 1'b0;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding cannot be routed and is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_resp_valid && fifo_empty_s)
      $display("%m: protocol error: mem_resp_valid with no outstanding read");
  end
`endif

`ifdef AMI_ARB_STATS_EN
  logic [31:0] stat_q [NUM_REQ];

  // Per-requester grant counters that stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst)                                          stat_q[i] <= 32'h0;
      else if (req_grant[i] && stat_q[i] != 32'hFFFF_FFFF) stat_q[i] <= stat_q[i] + 32'h1;
    end
  end

  // Pack counters onto the stats port.
  always_comb begin
    stat_grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grant_count[i*32 +: 32] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_ami_port_arbiter.sv
// Directed self-checking bench for ami_port_arbiter (4 requesters, 4-deep routing FIFO).
module tb_ami_port_arbiter;
  localparam int NR = 4, AW = 64, DW = 32, SW = 16, LTD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_is_write, req_grant, resp_valid, resp_grant;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR*SW-1:0]  req_size;
  logic [DW-1:0]     resp_data, mem_req_data, mem_resp_data;
  logic              mem_req_valid, mem_req_is_write, mem_req_grant;
  logic [AW-1:0]     mem_req_addr;
  logic [SW-1:0]     mem_req_size;
  logic              mem_resp_valid, mem_resp_grant;
  logic [LTD:0]      outstanding_reads;
`ifdef AMI_ARB_STATS_EN
  logic [NR*32-1:0]  stat_grant_count;
`endif

  int checks = 0;
  int errors = 0;

  ami_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW),
                     .LOG_TAG_DEPTH(LTD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_write(req_is_write), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .req_grant(req_grant),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_grant(resp_grant),
    .mem_req_valid(mem_req_valid), .mem_req_is_write(mem_req_is_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
    .mem_req_grant(mem_req_grant), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .mem_resp_grant(mem_resp_grant),
    .outstanding_reads(outstanding_reads)
`ifdef AMI_ARB_STATS_EN
    , .stat_grant_count(stat_grant_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic wr, input logic [AW-1:0] a);
    req_valid[i]           = v;
    req_is_write[i]        = wr;
    req_addr[i*AW +: AW]   = a;
    req_data[i*DW +: DW]   = 32'hDA7A_0000 | 32'(i);
    req_size[i*SW +: SW]   = 16'h0040;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 64'h0);
    mem_resp_valid = 1'b1; resp_grant = 4'hF; mem_req_grant = 1'b0;
    @(negedge clk); #1;
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL reset_req_grant: got %b expected 0000", req_grant); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (outstanding_reads !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding_reads); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
    checks++; if (mem_resp_grant !== 1'b0) begin errors++; $display("FAIL reset_mem_resp_grant: got %b expected 0", mem_resp_grant); end
    @(negedge clk);
    rst = 1'b0; req_valid = '0; mem_resp_valid = 1'b0; resp_grant = '0;
  endtask

  task automatic test_fairness;
    logic [NR-1:0] exp_g;
    logic [AW-1:0] exp_a;
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 64'h1000 + 64'(i) * 64'h100);
    mem_req_grant = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_g = 4'b0001 << (c % 4);
      checks++; if (req_grant !== exp_g) begin errors++; $display("FAIL fair_grant c%0d: got %b expected %b", c, req_grant, exp_g); end
      if (c > 0) begin
        exp_a = 64'h1000 + 64'((c - 1) % 4) * 64'h100;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_a) begin
          errors++; $display("FAIL fair_addr c%0d: got v=%b a=%h expected v=1 a=%h", c, mem_req_valid, mem_req_addr, exp_a);
        end
      end
    end
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fair_drain: got %b expected 0", mem_req_valid); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    mem_req_grant = 1'b0; set_req(2, 1'b1, 1'b1, 64'h40); #1;
    checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", req_grant); end
    @(negedge clk);
    set_req(2, 1'b0, 1'b1, 64'h0); set_req(0, 1'b1, 1'b1, 64'h2000);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL bp_no_grant c%0d: got %b expected 0000", c, req_grant); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h40 || mem_req_data !== 32'hDA7A_0002 ||
                    mem_req_is_write !== 1'b1 || mem_req_size !== 16'h0040) begin
        errors++; $display("FAIL bp_stable c%0d: got v=%b a=%h d=%h w=%b expected v=1 a=40 d=da7a0002 w=1",
                           c, mem_req_valid, mem_req_addr, mem_req_data, mem_req_is_write);
      end
    end
    @(negedge clk); mem_req_grant = 1'b1; #1;
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL bp_release_grant: got %b expected 0001", req_grant); end
    @(negedge clk); set_req(0, 1'b0, 1'b1, 64'h0); #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h2000) begin
      errors++; $display("FAIL bp_next: got v=%b a=%h expected v=1 a=2000", mem_req_valid, mem_req_addr);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_read_routing;
    @(negedge clk); set_req(1, 1'b1, 1'b0, 64'h0); #1;
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL rd_grant1: got %b expected 0010", req_grant); end
    @(negedge clk); set_req(1, 1'b0, 1'b0, 64'h0); set_req(3, 1'b1, 1'b0, 64'h40); #1;
    checks++; if (req_grant !== 4'b1000) begin errors++; $display("FAIL rd_grant3: got %b expected 1000", req_grant); end
    checks++; if (mem_req_is_write !== 1'b0 || mem_req_addr !== 64'h0) begin
      errors++; $display("FAIL rd_req1: got w=%b a=%h expected w=0 a=0", mem_req_is_write, mem_req_addr);
    end
    @(negedge clk); set_req(3, 1'b0, 1'b0, 64'h0); #1;
    checks++; if (outstanding_reads !== 3'd1) begin errors++; $display("FAIL rd_out1: got %0d expected 1", outstanding_reads); end
    @(negedge clk); #1;
    checks++; if (outstanding_reads !== 3'd2) begin errors++; $display("FAIL rd_out2: got %0d expected 2", outstanding_reads); end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hD0D0_0000; resp_grant = 4'b1000; #1;
    checks++; if (resp_valid !== 4'b0010 || mem_resp_grant !== 1'b0) begin
      errors++; $display("FAIL rd_head_not_ready: got rv=%b g=%b expected rv=0010 g=0", resp_valid, mem_resp_grant);
    end
    @(negedge clk); #1;
    checks++; if (outstanding_reads !== 3'd2) begin errors++; $display("FAIL rd_no_pop: got %0d expected 2", outstanding_reads); end
    resp_grant = 4'b0010; #1;
    checks++; if (resp_valid !== 4'b0010 || resp_data !== 32'hD0D0_0000 || mem_resp_grant !== 1'b1) begin
      errors++; $display("FAIL rd_resp0: got rv=%b d=%h g=%b expected rv=0010 d=d0d00000 g=1", resp_valid, resp_data, mem_resp_grant);
    end
    @(negedge clk); mem_resp_data = 32'hD1D1_0001; resp_grant = 4'b1000; #1;
    checks++; if (outstanding_reads !== 3'd1) begin errors++; $display("FAIL rd_out_after1: got %0d expected 1", outstanding_reads); end
    checks++; if (resp_valid !== 4'b1000 || resp_data !== 32'hD1D1_0001 || mem_resp_grant !== 1'b1) begin
      errors++; $display("FAIL rd_resp1: got rv=%b d=%h g=%b expected rv=1000 d=d1d10001 g=1", resp_valid, resp_data, mem_resp_grant);
    end
    @(negedge clk); mem_resp_valid = 1'b0; resp_grant = '0; #1;
    checks++; if (outstanding_reads !== 3'd0 || resp_valid !== 4'b0000) begin
      errors++; $display("FAIL rd_done: got out=%0d rv=%b expected out=0 rv=0000", outstanding_reads, resp_valid);
    end
  endtask

  task automatic test_fifo_full;
    logic [NR-1:0] exp_g;
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 64'h3000 + 64'(i) * 64'h100);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(negedge clk); set_req(c - 1, 1'b0, 1'b0, 64'h0); end
      #1;
      exp_g = 4'b0001 << c;
      checks++; if (req_grant !== exp_g) begin errors++; $display("FAIL full_fill c%0d: got %b expected %b", c, req_grant, exp_g); end
    end
    @(negedge clk); set_req(3, 1'b0, 1'b0, 64'h0); #1;
    checks++; if (outstanding_reads !== 3'd3) begin errors++; $display("FAIL full_out3: got %0d expected 3", outstanding_reads); end
    @(negedge clk); set_req(0, 1'b1, 1'b0, 64'h500); set_req(1, 1'b1, 1'b1, 64'h600); #1;
    checks++; if (outstanding_reads !== 3'd4) begin errors++; $display("FAIL full_out4: got %0d expected 4", outstanding_reads); end
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL full_write_only: got %b expected 0010", req_grant); end
    @(negedge clk); set_req(1, 1'b0, 1'b1, 64'h0); #1;
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL full_read_blocked: got %b expected 0000", req_grant); end
    checks++; if (mem_req_is_write !== 1'b1 || mem_req_addr !== 64'h600) begin
      errors++; $display("FAIL full_write_req: got w=%b a=%h expected w=1 a=600", mem_req_is_write, mem_req_addr);
    end
    @(negedge clk); #1;
    checks++; if (req_grant !== 4'b0000 || outstanding_reads !== 3'd4) begin
      errors++; $display("FAIL full_still_blocked: got g=%b out=%0d expected g=0000 out=4", req_grant, outstanding_reads);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_0000; resp_grant = 4'hF; #1;
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL full_resp_head: got %b expected 0001", resp_valid); end
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL full_unblock: got %b expected 0001", req_grant); end
    @(negedge clk); mem_resp_valid = 1'b0; set_req(0, 1'b0, 1'b0, 64'h0); #1;
    checks++; if (outstanding_reads !== 3'd3 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h500 || mem_req_is_write !== 1'b0) begin
      errors++; $display("FAIL full_read_issued: got out=%0d v=%b a=%h w=%b expected out=3 v=1 a=500 w=0",
                         outstanding_reads, mem_req_valid, mem_req_addr, mem_req_is_write);
    end
  endtask

  task automatic test_push_pop;
    logic [NR-1:0] exp_rv [3];
    exp_rv[0] = 4'b1000; exp_rv[1] = 4'b0001; exp_rv[2] = 4'b0100;
    @(negedge clk); #1;
    checks++; if (outstanding_reads !== 3'd4) begin errors++; $display("FAIL pp_out4: got %0d expected 4", outstanding_reads); end
    mem_resp_valid = 1'b1; #1;
    checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL pp_head1: got %b expected 0010", resp_valid); end
    @(negedge clk); mem_resp_valid = 1'b0; mem_req_grant = 1'b0; set_req(2, 1'b1, 1'b0, 64'h700); #1;
    checks++; if (outstanding_reads !== 3'd3 || req_grant !== 4'b0100) begin
      errors++; $display("FAIL pp_setup: got out=%0d g=%b expected out=3 g=0100", outstanding_reads, req_grant);
    end
    @(negedge clk); set_req(2, 1'b0, 1'b0, 64'h0); mem_req_grant = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hE0; #1;
    checks++; if (resp_valid !== 4'b0100 || mem_resp_grant !== 1'b1 || outstanding_reads !== 3'd3) begin
      errors++; $display("FAIL pp_collide: got rv=%b g=%b out=%0d expected rv=0100 g=1 out=3", resp_valid, mem_resp_grant, outstanding_reads);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (outstanding_reads !== 3'(3 - k) || resp_valid !== exp_rv[k]) begin
        errors++; $display("FAIL pp_order k%0d: got out=%0d rv=%b expected out=%0d rv=%b", k, outstanding_reads, resp_valid, 3 - k, exp_rv[k]);
      end
    end
    @(negedge clk); mem_resp_valid = 1'b0; #1;
    checks++; if (outstanding_reads !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d expected 0", outstanding_reads); end
  endtask

  task automatic test_mid_reset;
    @(negedge clk); set_req(3, 1'b1, 1'b0, 64'h800); #1;
    checks++; if (req_grant !== 4'b1000) begin errors++; $display("FAIL mr_grant3: got %b expected 1000", req_grant); end
    @(negedge clk); set_req(3, 1'b0, 1'b0, 64'h0); set_req(0, 1'b1, 1'b0, 64'h900); #1;
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL mr_grant0: got %b expected 0001", req_grant); end
    @(negedge clk); set_req(0, 1'b0, 1'b0, 64'h0); set_req(1, 1'b1, 1'b1, 64'hA00); #1;
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL mr_grant1: got %b expected 0010", req_grant); end
    @(negedge clk); set_req(1, 1'b0, 1'b1, 64'h0); mem_req_grant = 1'b0; #1;
    checks++; if (outstanding_reads !== 3'd2 || mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL mr_pre: got out=%0d v=%b expected out=2 v=1", outstanding_reads, mem_req_valid);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (mem_req_valid !== 1'b0 || outstanding_reads !== 3'd0) begin
      errors++; $display("FAIL mr_post: got v=%b out=%0d expected v=0 out=0", mem_req_valid, outstanding_reads);
    end
`ifdef AMI_ARB_STATS_EN
    checks++; if (stat_grant_count !== '0) begin errors++; $display("FAIL mr_stats: got %h expected 0", stat_grant_count); end
`endif
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 64'h0);
    #1;
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL mr_rr_ptr: got %b expected 0001", req_grant); end
    @(negedge clk); req_valid = '0; mem_req_grant = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_is_write = '0; req_addr = '0; req_data = '0; req_size = '0;
    resp_grant = '0; mem_req_grant = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_read_routing();
    test_fifo_full();
    test_push_pop();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
